// File: rtl/wb_buffer.sv
// In-order writeback queue: two producers (A older than B) in, one register-file write port out; define WB_BYPASS_EN to add read forwarding.
// Latency: an accepted result drives we3 in the next cycle when the queue was empty; it is forwardable until it is popped.
// Backpressure: in_ready drops while fewer than two slots are free; hold stalls the drain indefinitely without loss.
module wb_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    input  logic [AW-1:0]              a_addr,
    input  logic [DW-1:0]              a_data,
    input  logic                       b_valid,
    input  logic [AW-1:0]              b_addr,
    input  logic [DW-1:0]              b_data,
    output logic                       in_ready,
    input  logic                       hold,
    output logic                       we3,
    output logic [AW-1:0]              wa3,
    output logic [DW-1:0]              wd3,
    input  logic [AW-1:0]              ra1,
    input  logic [AW-1:0]              ra2,
    output logic                       byp1_hit,
    output logic [DW-1:0]              byp1_data,
    output logic                       byp2_hit,
    output logic [DW-1:0]              byp2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          a_acc;
    logic          b_acc;
    logic          pop;
    logic [PW-1:0] b_slot;

    // One extra bit so count+2 cannot wrap for small DEPTH.
    assign in_ready = ({1'b0, count_q} + (CW+1)'(2)) <= (CW+1)'(DEPTH);
    assign a_acc    = a_valid && in_ready && (a_addr != '0);
    assign b_acc    = b_valid && in_ready && (b_addr != '0);
    assign pop      = (count_q != '0) && !hold;
    assign b_slot   = a_acc ? (tail_q + PW'(1)) : tail_q;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q + PW'(a_acc) + PW'(b_acc);
        if (a_acc) begin
            mem_d[tail_q] = '{addr: a_addr, data: a_data};
        end
        if (b_acc) begin
            mem_d[b_slot] = '{addr: b_addr, data: b_data};
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(a_acc) + CW'(b_acc) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign count = count_q;
    assign we3   = pop;
    assign wa3   = pop ? mem_q[head_q].addr : '0;
    assign wd3   = pop ? mem_q[head_q].data : '0;

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        byp1_hit  = 1'b0;
        byp1_data = '0;
        byp2_hit  = 1'b0;
        byp2_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (k < int'(count_q)) begin
                if ((ra1 != '0) && (mem_q[idx].addr == ra1)) begin
                    byp1_hit  = 1'b1;
                    byp1_data = mem_q[idx].data;
                end
                if ((ra2 != '0) && (mem_q[idx].addr == ra2)) begin
                    byp2_hit  = 1'b1;
                    byp2_data = mem_q[idx].data;
                end
            end
        end
    end
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};
    assign byp1_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_hit  = 1'b0;
    assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Bench for wb_buffer: directed vector table, reset-in-flight sequence, then random traffic against a queue model.
module tb_wb_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH+1);
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, hold;
    logic [AW-1:0] a_addr, b_addr, ra1, ra2;
    logic [DW-1:0] a_data, b_data;
    logic          in_ready, we3, byp1_hit, byp2_hit;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3, byp1_data, byp2_data;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    wb_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .in_ready(in_ready), .hold(hold),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_hit(byp2_hit), .byp2_data(byp2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ment_t;

    ment_t mq[$];

    typedef struct {
        logic av; logic [AW-1:0] aa; logic [DW-1:0] ad;
        logic bv; logic [AW-1:0] ba; logic [DW-1:0] bd;
        logic hold; logic [AW-1:0] r1; logic [AW-1:0] r2;
        logic we; logic [AW-1:0] wa; logic [DW-1:0] wd;
        int cnt; logic rdy;
        logic h1; logic [DW-1:0] d1; logic h2; logic [DW-1:0] d2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each rising edge using the inputs the DUT sees there.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
        end else begin
            bit rdy;
            rdy = (DEPTH - mq.size()) >= 2;
            if (mq.size() > 0 && !hold) void'(mq.pop_front());
            if (rdy && a_valid && a_addr != 0) mq.push_back('{addr: a_addr, data: a_data});
            if (rdy && b_valid && b_addr != 0) mq.push_back('{addr: b_addr, data: b_data});
        end
        #1;
    endtask

    task automatic model_check();
        int n;
        logic e_we, e_h1, e_h2;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd, e_d1, e_d2;
        n = mq.size();
        e_we = (n > 0) && !hold;
        e_wa = e_we ? mq[0].addr : '0;
        e_wd = e_we ? mq[0].data : '0;
        e_h1 = 0; e_d1 = '0; e_h2 = 0; e_d2 = '0;
        for (int k = 0; k < n; k++) begin
            if (ra1 != 0 && mq[k].addr == ra1) begin e_h1 = 1; e_d1 = mq[k].data; end
            if (ra2 != 0 && mq[k].addr == ra2) begin e_h2 = 1; e_d2 = mq[k].data; end
        end
        if (!BYP) begin e_h1 = 0; e_d1 = '0; e_h2 = 0; e_d2 = '0; end
        chk("rnd_count", count, n);
        chk("rnd_in_ready", in_ready, (DEPTH - n) >= 2);
        chk("rnd_we3", we3, e_we);
        chk("rnd_wa3", wa3, e_wa);
        chk("rnd_wd3", wd3, e_wd);
        chk("rnd_byp1_hit", byp1_hit, e_h1);
        chk("rnd_byp1_data", byp1_data, e_d1);
        chk("rnd_byp2_hit", byp2_hit, e_h2);
        chk("rnd_byp2_data", byp2_data, e_d2);
    endtask

    function automatic vec_t mk(int av, int aa, int ad, int bv, int ba, int bd, int h, int r1, int r2,
                                int we, int wa, int wd, int cnt, int rdy, int h1, int d1, int h2, int d2);
        vec_t v;
        v.av = av[0]; v.aa = AW'(aa); v.ad = DW'(ad);
        v.bv = bv[0]; v.ba = AW'(ba); v.bd = DW'(bd);
        v.hold = h[0]; v.r1 = AW'(r1); v.r2 = AW'(r2);
        v.we = we[0]; v.wa = AW'(wa); v.wd = DW'(wd);
        v.cnt = cnt; v.rdy = rdy[0];
        v.h1 = h1[0]; v.d1 = DW'(d1); v.h2 = h2[0]; v.d2 = DW'(d2);
        return v;
    endfunction

    task automatic idle_inputs();
        a_valid = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0;
        hold = 0; ra1 = '0; ra2 = '0;
    endtask

    initial begin
        // Expected outputs are those seen in the cycle the row is applied, before its edge.
        tbl.push_back(mk(1,2,12, 0,0,0,  0, 2,0, 0,0,0,  0,1, 0,0,  0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 2,0, 1,2,12, 1,1, 1,12, 0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 2,0, 0,0,0,  0,1, 0,0,  0,0));
        tbl.push_back(mk(1,3,5,  1,3,9,  1, 0,0, 0,0,0,  0,1, 0,0,  0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  1, 3,3, 0,0,0,  2,1, 1,9,  1,9));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 3,0, 1,3,5,  2,1, 1,9,  0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 3,0, 1,3,9,  1,1, 1,9,  0,0));
        tbl.push_back(mk(0,0,0,  1,0,77, 0, 0,0, 0,0,0,  0,1, 0,0,  0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 0,0, 0,0,0,  0,1, 0,0,  0,0));
        tbl.push_back(mk(1,4,40, 0,0,0,  1, 0,0, 0,0,0,  0,1, 0,0,  0,0));
        tbl.push_back(mk(1,5,50, 1,6,60, 1, 0,0, 0,0,0,  1,1, 0,0,  0,0));
        tbl.push_back(mk(1,7,70, 1,8,80, 1, 4,0, 0,0,0,  3,0, 1,40, 0,0));
        tbl.push_back(mk(1,7,70, 1,8,80, 1, 7,0, 0,0,0,  3,0, 0,0,  0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 5,6, 1,4,40, 3,0, 1,50, 1,60));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 4,0, 1,5,50, 2,1, 0,0,  0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 0,0, 1,6,60, 1,1, 0,0,  0,0));
        tbl.push_back(mk(0,0,0,  0,0,0,  0, 0,0, 0,0,0,  0,1, 0,0,  0,0));

        rst_n = 0;
        idle_inputs();
        ra1 = 5'd3;
        #2;
        chk("rst_we3", we3, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_byp1_hit", byp1_hit, 0);
        chk("rst_byp1_data", byp1_data, 0);
        tick();
        rst_n = 1;
        ra1 = '0;

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
            hold = tbl[i].hold; ra1 = tbl[i].r1; ra2 = tbl[i].r2;
            @(negedge clk);
            chk({tag, "_we3"}, we3, tbl[i].we);
            chk({tag, "_wa3"}, wa3, tbl[i].wa);
            chk({tag, "_wd3"}, wd3, tbl[i].wd);
            chk({tag, "_count"}, count, tbl[i].cnt);
            chk({tag, "_in_ready"}, in_ready, tbl[i].rdy);
            chk({tag, "_byp1_hit"}, byp1_hit, BYP ? tbl[i].h1 : 1'b0);
            chk({tag, "_byp1_data"}, byp1_data, BYP ? tbl[i].d1 : '0);
            chk({tag, "_byp2_hit"}, byp2_hit, BYP ? tbl[i].h2 : 1'b0);
            chk({tag, "_byp2_data"}, byp2_data, BYP ? tbl[i].d2 : '0);
            tick();
        end

        // Reset while entries are still queued: everything queued is dropped.
        idle_inputs();
        hold = 1;
        a_valid = 1; a_addr = 5'd10; a_data = 100;
        b_valid = 1; b_addr = 5'd11; b_data = 110;
        tick();
        a_addr = 5'd12; a_data = 120; b_valid = 0;
        tick();
        a_valid = 0; hold = 0; ra1 = 5'd11;
        @(negedge clk);
        chk("mr_count3", count, 3);
        chk("mr_first_wa3", wa3, 10);
        tick();
        @(negedge clk);
        chk("mr_second_wa3", wa3, 11);
        #1 rst_n = 0;
        #1;
        chk("mr_we3", we3, 0);
        chk("mr_wa3", wa3, 0);
        chk("mr_wd3", wd3, 0);
        chk("mr_count", count, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_byp1_hit", byp1_hit, 0);
        tick();
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mr_post_we3", we3, 0);
            chk("mr_post_count", count, 0);
            tick();
        end

        // Random traffic with drain-hold pressure sweeping from light to heavy.
        for (int c = 0; c < 3000; c++) begin
            int hold_pct;
            hold_pct = (c < 1000) ? 15 : (c < 2000) ? 50 : 85;
            a_valid = $urandom_range(0, 99) < 70;
            a_addr  = AW'($urandom_range(0, 7));
            a_data  = $urandom;
            b_valid = $urandom_range(0, 99) < 60;
            b_addr  = AW'($urandom_range(0, 7));
            b_data  = $urandom;
            hold    = $urandom_range(0, 99) < hold_pct;
            ra1     = AW'($urandom_range(0, 7));
            ra2     = AW'($urandom_range(0, 7));
            @(negedge clk);
            model_check();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
